// File: rtl/bitonic_pkg.sv
// ============================================================================
// Module      : bitonic_pkg
// Description : State encoding and schedule helpers shared by the iterative
//               bitonic sorter controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitonic_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Number of compare-exchange steps in a full bitonic network of 2**log_n keys.
    function automatic int sort_cycles(input int log_n);
        return ((1 << log_n) / 2) * log_n * (log_n + 1) / 2;
    endfunction

    // Inserts a zero bit at position s of p: lower index of the pair p at distance 2**s.
    function automatic logic [31:0] pair_lo(input logic [31:0] p, input logic [31:0] s);
        return ((p >> s) << (s + 32'd1)) | (p & ((32'd1 << s) - 32'd1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitonic_cx_cmp.sv
// ============================================================================
// Module      : bitonic_cx_cmp
// Description : Shared compare stage; flags when a key pair must be exchanged
//               to respect the requested direction. Equal keys never swap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitonic_cx_cmp #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  asc,
    output logic                  swap
);

    assign swap = asc ? (a > b) : (a < b);

endmodule

`default_nettype wire

// File: rtl/bitonic_sched.sv
// ============================================================================
// Module      : bitonic_sched
// Description : Iterative bitonic sorter: loads N keys, walks the bitonic
//               schedule one compare-exchange per cycle, then streams out.
//               Optional macro BITONIC_SCHED_STATS_EN adds a swap counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitonic_sched
    import bitonic_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int LOG_N      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ASCENDING,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
`ifdef BITONIC_SCHED_STATS_EN
    ,
    output logic [$clog2(sort_cycles(LOG_N)+1)-1:0] swap_count
`endif
);

    localparam int c_n    = 1 << LOG_N;
    localparam int c_half = c_n / 2;

    state_t                r_state;
    state_t                w_state_next;
    logic [LOG_N-1:0]      r_wr_idx;
    logic [LOG_N-1:0]      r_rd_idx;
    logic [LOG_N-1:0]      r_k_exp;
    logic [LOG_N-1:0]      r_j_exp;
    logic [LOG_N-1:0]      r_p;
    logic                  r_dir;
    logic [DATA_WIDTH-1:0] r_mem [c_n];

    logic                  w_accept;
    logic                  w_out_fire;
    logic                  w_load_done;
    logic                  w_last_pair;
    logic                  w_p_last;
    logic [LOG_N-1:0]      w_lo;
    logic [LOG_N-1:0]      w_hi;
    logic [31:0]           w_kmask;
    logic                  w_kbit;
    logic                  w_asc;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_swap;

    // ------------------------------------------------------------------
    // Handshakes and status
    // ------------------------------------------------------------------
    assign in_ready    = (r_state == ST_LOAD) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_load_done = w_accept && (r_wr_idx == LOG_N'(c_n - 1));

    assign out_valid   = (r_state == ST_DRAIN);
    assign out_data    = out_valid ? r_mem[r_rd_idx] : '0;
    assign out_last    = out_valid && (r_rd_idx == LOG_N'(c_n - 1));
    assign w_out_fire  = out_valid && out_ready;
    assign busy        = (r_state != ST_LOAD);

    // ------------------------------------------------------------------
    // Pair addressing for the current (k, j, p) point of the schedule
    // ------------------------------------------------------------------
    assign w_lo    = LOG_N'(pair_lo(32'(r_p), 32'(r_j_exp)));
    assign w_hi    = w_lo | LOG_N'(32'd1 << r_j_exp);
    // k = 2 << k_exp; for k == N the mask lies above the index and yields 0.
    assign w_kmask = 32'd2 << r_k_exp;
    assign w_kbit  = |(32'(w_lo) & w_kmask);
    assign w_asc   = r_dir ^ w_kbit;

    assign w_a = r_mem[w_lo];
    assign w_b = r_mem[w_hi];

    assign w_p_last    = (r_p == LOG_N'(c_half - 1));
    assign w_last_pair = w_p_last && (r_j_exp == '0) && (r_k_exp == LOG_N'(LOG_N - 1));

    bitonic_cx_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cx_cmp (
        .a    (w_a),
        .b    (w_b),
        .asc  (w_asc),
        .swap (w_swap)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:  if (w_load_done) w_state_next = ST_SORT;
            ST_SORT:  if (w_last_pair) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_out_fire && out_last) w_state_next = ST_LOAD;
            default:  w_state_next = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Index counters and latched sort direction
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_k_exp  <= '0;
            r_j_exp  <= '0;
            r_p      <= '0;
            r_dir    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (r_wr_idx == '0) begin
                            r_dir <= ASCENDING;
                        end
                        if (w_load_done) begin
                            r_wr_idx <= '0;
                            r_k_exp  <= '0;
                            r_j_exp  <= '0;
                            r_p      <= '0;
                        end else begin
                            r_wr_idx <= r_wr_idx + LOG_N'(1);
                        end
                    end
                end
                ST_SORT: begin
                    if (w_last_pair) begin
                        r_rd_idx <= '0;
                    end else if (w_p_last) begin
                        r_p <= '0;
                        if (r_j_exp == '0) begin
                            // Next merge stage starts with j = k/2, i.e. s = new k_exp.
                            r_k_exp <= r_k_exp + LOG_N'(1);
                            r_j_exp <= r_k_exp + LOG_N'(1);
                        end else begin
                            r_j_exp <= r_j_exp - LOG_N'(1);
                        end
                    end else begin
                        r_p <= r_p + LOG_N'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_out_fire) begin
                        if (out_last) begin
                            r_rd_idx <= '0;
                            r_wr_idx <= '0;
                        end else begin
                            r_rd_idx <= r_rd_idx + LOG_N'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key buffer: written by the loader or by the exchange, never both
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_idx] <= in_data;
        end else if ((r_state == ST_SORT) && w_swap) begin
            r_mem[w_lo] <= w_b;
            r_mem[w_hi] <= w_a;
        end
    end

`ifdef BITONIC_SCHED_STATS_EN
    localparam int c_sc_w = $clog2(sort_cycles(LOG_N) + 1);

    logic [c_sc_w-1:0] r_swap_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swap_count <= '0;
        end else if (w_load_done) begin
            r_swap_count <= '0;
        end else if ((r_state == ST_SORT) && w_swap) begin
            r_swap_count <= r_swap_count + c_sc_w'(1);
        end
    end

    assign swap_count = r_swap_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitonic_sched.sv
// ============================================================================
// Module      : tb_bitonic_sched
// Description : Self-checking bench for bitonic_sched against a sorted-queue
//               reference model with directed and randomized batches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitonic_sched;

    localparam int DW       = 4;
    localparam int LN       = 3;
    localparam int N        = 1 << LN;
    localparam int SORT_CYC = (N / 2) * LN * (LN + 1) / 2;

    typedef logic [DW-1:0] batch_t [N];

    logic          clk;
    logic          rst;
    logic          ASCENDING;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef BITONIC_SCHED_STATS_EN
    logic [$clog2(SORT_CYC+1)-1:0] swap_count;
`endif

    int n_total = 0;
    int n_bad   = 0;

    bitonic_sched #(
        .DATA_WIDTH (DW),
        .LOG_N      (LN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ASCENDING  (ASCENDING),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
`ifdef BITONIC_SCHED_STATS_EN
        ,
        .swap_count (swap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the sorted batch, straight from the queue sort methods.
    task automatic ref_sort(input batch_t v, input bit asc, output batch_t e);
        int q[$];
        foreach (v[i]) q.push_back(int'(v[i]));
        if (asc) q.sort();
        else     q.rsort();
        foreach (e[i]) e[i] = DW'(q[i]);
    endtask

    // Reference swap count: classic i^j bitonic network applied to an array.
    function automatic int count_swaps(input batch_t v, input bit asc);
        int a[N];
        int n_sw = 0;
        foreach (v[i]) a[i] = int'(v[i]);
        for (int k = 2; k <= N; k = k * 2) begin
            for (int j = k / 2; j >= 1; j = j / 2) begin
                for (int i = 0; i < N; i++) begin
                    int h;
                    bit up;
                    h = i ^ j;
                    if (h > i) begin
                        up = asc ^ ((i & k) != 0);
                        if ((up && a[i] > a[h]) || (!up && a[i] < a[h])) begin
                            int t;
                            t = a[i]; a[i] = a[h]; a[h] = t;
                            n_sw++;
                        end
                    end
                end
            end
        end
        return n_sw;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check_val("rst_release_ready", in_ready, 1);
    endtask

    // Loads a batch; ASCENDING is flipped after the first accept to show it is ignored.
    task automatic load_batch(input batch_t v, input bit asc, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                tick();
            end
            in_valid  = 1'b1;
            in_data   = v[i];
            ASCENDING = (i == 0) ? asc : ~asc;
            if (i == 0) check_val("load_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Counts edges from the Nth accept to the first out_valid while spraying in_valid.
    task automatic wait_sort();
        int cnt = 0;
        bit rdy_seen = 0;
        bit busy_low = 0;
        while (!out_valid && cnt < 200) begin
            if (in_ready) rdy_seen = 1;
            if (!busy)    busy_low = 1;
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            tick();
            cnt++;
        end
        in_valid = 1'b0;
        check_val("latency", cnt, SORT_CYC);
        check_val("ready_in_sort", rdy_seen, 0);
        check_val("busy_low_in_sort", busy_low, 0);
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1,0,1 repeating, 2: random.
    task automatic drain(input batch_t e, input int mode, input int n_take);
        int idx = 0;
        int cyc = 0;
        while (idx < n_take && cyc < 500) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 6) == 0) || ((cyc % 6) == 3) || ((cyc % 6) == 5);
                default: out_ready = 1'($urandom);
            endcase
            check_val("out_valid", out_valid, 1);
            check_val("out_data", out_data, e[idx]);
            check_val("out_last", out_last, (idx == N - 1));
            check_val("busy_drain", busy, 1);
            if (out_ready) idx++;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check_val("drain_count", idx, n_take);
    endtask

    task automatic run_batch(input batch_t v, input bit asc, input bit gaps, input int mode);
        batch_t e;
        ref_sort(v, asc, e);
        load_batch(v, asc, gaps);
        wait_sort();
`ifdef BITONIC_SCHED_STATS_EN
        check_val("swap_count", swap_count, count_swaps(v, asc));
`endif
        drain(e, mode, N);
        check_val("post_out_valid", out_valid, 0);
        check_val("post_busy", busy, 0);
        check_val("post_in_ready", in_ready, 1);
    endtask

    initial begin
        batch_t b;
        batch_t e;
        rst       = 1'b1;
        ASCENDING = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("init_out_valid", out_valid, 0);
        check_val("init_busy", busy, 0);
        check_val("init_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        check_val("init_in_ready", in_ready, 1);

        b = '{7, 3, 6, 0, 5, 1, 4, 2};
        run_batch(b, 1'b1, 1'b0, 0);

        b = '{2, 9, 2, 15, 0, 9, 4, 4};
        run_batch(b, 1'b0, 1'b0, 0);

        foreach (b[i]) b[i] = DW'($urandom);
        run_batch(b, 1'b1, 1'b0, 1);

        b = '{5, 5, 5, 5, 5, 5, 5, 5};
        run_batch(b, 1'b1, 1'b1, 0);
`ifdef BITONIC_SCHED_STATS_EN
        check_val("swap_count_equal", swap_count, 0);
`endif

        // Abort in the middle of SORT.
        foreach (b[i]) b[i] = DW'($urandom);
        load_batch(b, 1'b1, 1'b0);
        repeat (10) tick();
        check_val("busy_mid_sort", busy, 1);
        do_reset();
        check_val("abort_sort_valid", out_valid, 0);
        b = '{1, 0, 3, 2, 5, 4, 7, 6};
        run_batch(b, 1'b1, 1'b0, 0);

        // Abort in DRAIN after three words.
        foreach (b[i]) b[i] = DW'($urandom);
        ref_sort(b, 1'b0, e);
        load_batch(b, 1'b0, 1'b0);
        wait_sort();
        drain(e, 0, 3);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("abort_drain_valid", out_valid, 0);
            tick();
        end
        out_ready = 1'b0;
        foreach (b[i]) b[i] = DW'($urandom);
        run_batch(b, 1'b1, 1'b0, 0);

        for (int t = 0; t < 10; t++) begin
            foreach (b[i]) b[i] = DW'($urandom);
            run_batch(b, 1'($urandom), 1'($urandom), 2);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bitonic_sched.md
Name: bitonic_sched

Overview:
- Iterative bitonic sorter controller. Buffers one batch of N words and drives a single shared compare-exchange datapath, one pair per cycle, through the full bitonic schedule.
- Streams the sorted batch out with a valid/ready handshake.
- Used where area matters more than throughput, instead of the fully unrolled network.

Parameters:
- DATA_WIDTH, 4, width of each key, compared unsigned.
- LOG_N, 3, log2 of batch size; N = 2**LOG_N, legal range 1..6.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ASCENDING  in  1  sort direction, sampled on the first accepted word of a batch
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input (LOAD state only)
- in_data  in  DATA_WIDTH  input key
- out_valid  out  1  sorted word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  sorted key
- out_last  out  1  marks word N-1 of the batch
- busy  out  1  high in SORT or DRAIN

Behaviour:
- Reset (async): state=LOAD; all indices 0; out_valid=0, out_last=0, busy=0, out_data=0. Buffer contents are don't-care. in_ready = (state==LOAD) && !rst.
- LOAD: on in_valid&&in_ready, mem[wr_idx] <= in_data and wr_idx++. The first accept latches dir <= ASCENDING. Gaps on in_valid are allowed. The accept with wr_idx==N-1 moves the state to SORT and zeroes k_exp, j_exp and p.
- SORT: one compare per cycle; no handshake.
  - Loop order: k = 2,4,..,N (outer); j = k/2 down to 1 (middle); p = 0..N/2-1 (inner).
  - With s=log2(j): lo = ((p>>s)<<(s+1)) | (p & (j-1)), hi = lo | j.
  - Pair direction is ascending iff dir XOR ((lo & k) != 0) equals 1, i.e. ascending when dir=1 and (lo & k)==0.
  - Swap iff (ascending && mem[lo] > mem[hi]) || (!ascending && mem[lo] < mem[hi]). Equal keys never swap.
  - Swap writes both entries at the same edge; a non-swap writes nothing.
  - SORT lasts exactly (N/2)*LOG_N*(LOG_N+1)/2 cycles (24 for N=8). After the final pair, state goes to DRAIN with rd_idx=0.
- DRAIN: out_valid=1, out_data=mem[rd_idx], out_last=(rd_idx==N-1).
  - On out_valid&&out_ready, rd_idx++.
  - The handshake with out_last=1 goes to LOAD with wr_idx=0 and out_valid=0 at the next cycle.
  - out_data and out_last stay stable while out_valid&&!out_ready.
- Latency: first out_valid is high in the 25th cycle after the Nth-accept edge (N=8), i.e. SORT cycles + 1.
- in_ready is 0 throughout SORT and DRAIN. in_valid there is ignored and no data is lost upstream.
- ASCENDING changes after the first accept have no effect on the current batch.
- Reset mid-LOAD, mid-SORT or mid-DRAIN aborts the batch. Outputs take reset values immediately; the next batch behaves as after power-up.
- N=2 (LOG_N=1): SORT is one cycle.
- All index counters are LOG_N bits wide and have no wrap beyond the ranges above.

Optional Feature:
- Macro: BITONIC_SCHED_STATS_EN.
- Defined: adds output swap_count, width clog2(SORT cycles + 1).
  - Cleared on the cycle SORT is entered; +1 per swapping cycle.
  - Holds its value through DRAIN and LOAD until the next SORT.
  - Reset value 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Package bitonic_pkg:
  - state encoding (LOAD, SORT, DRAIN)
  - function sort_cycles(LOG_N)
  - function pair_lo(p, s) for bit insertion
- Sub-module bitonic_cx_cmp: combinational; inputs a, b, asc; output swap. This is the shared compare datapath, instantiated once.
- Controller, indices and buffer stay in bitonic_sched.

Test Plan:
- Ascending sort: N=8, ASCENDING=1, load 7,3,6,0,5,1,4,2 → out 0,1,2,3,4,5,6,7; out_last only on 7; first out_valid 25 cycles after the 8th accept; in_ready=0 for that whole window.
- Descending with duplicates: ASCENDING=0, load 2,9,2,15,0,9,4,4 → out 15,9,9,4,4,2,2,0. Toggling ASCENDING after the first accept changes nothing.
- Backpressure: out_ready pattern 1,0,0,1,0,1,... during DRAIN → each word held stable until accepted; exactly 8 handshakes; next LOAD accepts a new batch.
- Input gaps: in_valid low on alternating cycles while loading 5,5,5,5,5,5,5,5 → all out 5. With the EN macro defined, swap_count=0.
- Reset mid-SORT: assert rst 10 cycles into SORT → out_valid=0, busy=0, in_ready=1 after release; batch 1,0,3,2,5,4,7,6 ascending → 0..7.
- Reset during DRAIN after 3 words: remaining words never appear; a following batch sorts correctly.
